// File: rtl/pc_stack_push_if.sv
// Bus between the control FSM / memory write port and the PC stack-push engine.
interface pc_stack_push_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
);
   logic              push_i;
   logic [ADDR_W-1:0] pc_i;
   logic [ADDR_W-1:0] sp_i;
   logic              busy_o;
   logic              done_o;
   logic              sp_load_o;
   logic [ADDR_W-1:0] sp_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_o;
   logic              mem_wr_o;
   logic              mem_ack_i;

   // Push engine side
   modport slave (
      input  push_i, pc_i, sp_i, mem_ack_i,
      output busy_o, done_o, sp_load_o, sp_o, mem_addr_o, mem_data_o, mem_wr_o
   );

   // Controller / memory side
   modport master (
      output push_i, pc_i, sp_i, mem_ack_i,
      input  busy_o, done_o, sp_load_o, sp_o, mem_addr_o, mem_data_o, mem_wr_o
   );
endinterface

// File: rtl/pc_stack_push.sv
// Pushes a PC onto the 8080 stack as two byte writes (PCH to SP-1, PCL to SP-2)
// and reports SP-2 back to the register file.
module pc_stack_push #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk50M_i,
   input  logic              rst_ni,
   pc_stack_push_if.slave    bus
);

   localparam logic [ADDR_W-1:0] SpOne = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] SpTwo = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] SpRst = ADDR_W'(0) - SpTwo;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWrHi = 2'd1,
      StWrLo = 2'd2,
      StDone = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] sp_q, sp_d;

   logic              busy_d;
   logic              done_d;
   logic              sp_load_d;
   logic [ADDR_W-1:0] sp_o_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_data_d;
   logic              mem_wr_d;

   // Next state and next (registered) Moore outputs decoded from the next state
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      sp_d       = sp_q;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      sp_load_d  = 1'b0;
      mem_addr_d = '0;
      mem_data_d = '0;
      mem_wr_d   = 1'b0;

      case (state_q)
         StIdle: begin
            if (bus.push_i) begin
               pc_d    = bus.pc_i;
               sp_d    = bus.sp_i;
               state_d = StWrHi;
            end
         end
         StWrHi:  if (bus.mem_ack_i) state_d = StWrLo;
         StWrLo:  if (bus.mem_ack_i) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      sp_o_d = sp_d - SpTwo;

      case (state_d)
         StWrHi: begin
            busy_d     = 1'b1;
            mem_wr_d   = 1'b1;
            mem_addr_d = sp_d - SpOne;
            mem_data_d = pc_d[ADDR_W-1:DATA_W];
         end
         StWrLo: begin
            busy_d     = 1'b1;
            mem_wr_d   = 1'b1;
            mem_addr_d = sp_d - SpTwo;
            mem_data_d = pc_d[DATA_W-1:0];
         end
         StDone: begin
            busy_d    = 1'b1;
            done_d    = 1'b1;
            sp_load_d = 1'b1;
         end
         default: ;
      endcase
   end

   // State, captured operands and output registers; reset aborts any write in flight
   always_ff @(posedge clk50M_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= StIdle;
         pc_q           <= '0;
         sp_q           <= '0;
         bus.busy_o     <= 1'b0;
         bus.done_o     <= 1'b0;
         bus.sp_load_o  <= 1'b0;
         bus.sp_o       <= SpRst;
         bus.mem_addr_o <= '0;
         bus.mem_data_o <= '0;
         bus.mem_wr_o   <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         sp_q           <= sp_d;
         bus.busy_o     <= busy_d;
         bus.done_o     <= done_d;
         bus.sp_load_o  <= sp_load_d;
         bus.sp_o       <= sp_o_d;
         bus.mem_addr_o <= mem_addr_d;
         bus.mem_data_o <= mem_data_d;
         bus.mem_wr_o   <= mem_wr_d;
      end
   end

endmodule

// File: tb/tb_pc_stack_push.sv
// Scoreboard bench for pc_stack_push: expected writes/done events are queued when
// a push is driven and retired by a monitor as the DUT performs them.
module tb_pc_stack_push;

   typedef struct packed {
      logic        is_done;
      logic [15:0] addr;   // write address, or expected sp_o for a done event
      logic [7:0]  data;
   } exp_t;

   logic clk;
   logic rst_n;

   pc_stack_push_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   pc_stack_push #(.ADDR_W(16), .DATA_W(8)) dut (
      .clk50M_i (clk),
      .rst_ni   (rst_n),
      .bus      (bus.slave)
   );

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue the three events a push of (pc, sp) must produce
   task automatic expect_push(input logic [15:0] pc, input logic [15:0] sp);
      exp_q.push_back('{1'b0, sp - 16'd1, pc[15:8]});
      exp_q.push_back('{1'b0, sp - 16'd2, pc[7:0]});
      exp_q.push_back('{1'b1, sp - 16'd2, 8'h00});
   endtask

   // Single-cycle push request from idle; returns in the first StWrHi cycle
   task automatic do_push(input logic [15:0] pc, input logic [15:0] sp);
      expect_push(pc, sp);
      bus.push_i = 1'b1;
      bus.pc_i   = pc;
      bus.sp_i   = sp;
      tick();
      bus.push_i = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && bus.busy_o; i++) tick();
      check("idle_timeout", 32'(bus.busy_o), 32'd0);
   endtask

   // Retire expected events as the DUT completes writes and done pulses
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_wr_o && bus.mem_ack_i) begin
            if (exp_q.size() == 0) check("unexp_wr", 32'(exp_q.size()), 32'd1);
            else begin
               mon_e = exp_q.pop_front();
               check("wr_kind", 32'(mon_e.is_done), 32'd0);
               check("wr_addr", 32'(bus.mem_addr_o), 32'(mon_e.addr));
               check("wr_data", 32'(bus.mem_data_o), 32'(mon_e.data));
            end
         end
         if (bus.done_o) begin
            if (exp_q.size() == 0) check("unexp_done", 32'(exp_q.size()), 32'd1);
            else begin
               mon_e = exp_q.pop_front();
               check("done_kind", 32'(mon_e.is_done), 32'd1);
               check("done_sp", 32'(bus.sp_o), 32'(mon_e.addr));
               check("done_spload", 32'(bus.sp_load_o), 32'd1);
               check("done_wr", 32'(bus.mem_wr_o), 32'd0);
            end
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      bus.push_i    = 1'b0;
      bus.pc_i      = '0;
      bus.sp_i      = '0;
      bus.mem_ack_i = 1'b0;
      tick(); tick();

      // Reset values
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      check("rst_done", 32'(bus.done_o), 32'd0);
      check("rst_spload", 32'(bus.sp_load_o), 32'd0);
      check("rst_wr", 32'(bus.mem_wr_o), 32'd0);
      check("rst_addr", 32'(bus.mem_addr_o), 32'd0);
      check("rst_data", 32'(bus.mem_data_o), 32'd0);
      check("rst_sp", 32'(bus.sp_o), 32'hFFFE);
      rst_n = 1'b1;
      tick();

      // 1: ack tied high, cycle-exact latency
      bus.mem_ack_i = 1'b1;
      do_push(16'h1234, 16'h2400);
      check("t1_c1_wr", 32'(bus.mem_wr_o), 32'd1);
      check("t1_c1_addr", 32'(bus.mem_addr_o), 32'h23FF);
      check("t1_c1_data", 32'(bus.mem_data_o), 32'h12);
      check("t1_c1_busy", 32'(bus.busy_o), 32'd1);
      tick();
      check("t1_c2_addr", 32'(bus.mem_addr_o), 32'h23FE);
      check("t1_c2_data", 32'(bus.mem_data_o), 32'h34);
      tick();
      check("t1_c3_done", 32'(bus.done_o), 32'd1);
      check("t1_c3_sp", 32'(bus.sp_o), 32'h23FE);
      tick();
      check("t1_c4_busy", 32'(bus.busy_o), 32'd0);
      check("t1_c4_done", 32'(bus.done_o), 32'd0);

      // 2: ack withheld for 3 cycles in the high-byte phase
      bus.mem_ack_i = 1'b0;
      do_push(16'hABCD, 16'h8000);
      for (int i = 0; i < 3; i++) begin
         check("t2_stall_wr", 32'(bus.mem_wr_o), 32'd1);
         check("t2_stall_addr", 32'(bus.mem_addr_o), 32'h7FFF);
         check("t2_stall_data", 32'(bus.mem_data_o), 32'hAB);
         if (i < 2) tick();
      end
      bus.mem_ack_i = 1'b1;
      tick();
      check("t2_lo_addr", 32'(bus.mem_addr_o), 32'h7FFE);
      wait_idle();

      // 3: SP wrap-around
      do_push(16'h0102, 16'h0000);
      check("t3a_hi_addr", 32'(bus.mem_addr_o), 32'hFFFF);
      wait_idle();
      do_push(16'h0304, 16'h0001);
      check("t3b_hi_addr", 32'(bus.mem_addr_o), 32'h0000);
      wait_idle();

      // 4: push held high with changing pc during busy -> exactly one push
      expect_push(16'h5678, 16'h1000);
      bus.push_i = 1'b1;
      bus.pc_i   = 16'h5678;
      bus.sp_i   = 16'h1000;
      tick();
      bus.pc_i = 16'h1111; bus.sp_i = 16'h2000;
      tick();
      bus.pc_i = 16'h2222;
      tick();
      check("t4_done", 32'(bus.done_o), 32'd1);
      bus.pc_i = 16'h3333;
      tick();
      bus.push_i = 1'b0;
      check("t4_idle_busy", 32'(bus.busy_o), 32'd0);
      tick();
      check("t4_no_requeue", 32'(bus.busy_o), 32'd0);
      // ack pulses while idle
      for (int i = 0; i < 4; i++) begin
         bus.mem_ack_i = i[0];
         tick();
         check("t4_idle_wr", 32'(bus.mem_wr_o), 32'd0);
         check("t4_idle_done", 32'(bus.done_o), 32'd0);
      end

      // 5: reset during the low-byte phase
      bus.mem_ack_i = 1'b1;
      do_push(16'h4321, 16'h3000);
      tick();
      bus.mem_ack_i = 1'b0;
      check("t5_lo_addr", 32'(bus.mem_addr_o), 32'h2FFE);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_wr", 32'(bus.mem_wr_o), 32'd0);
      check("t5_rst_busy", 32'(bus.busy_o), 32'd0);
      check("t5_rst_sp", 32'(bus.sp_o), 32'hFFFE);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick(); tick();
      check("t5_no_done", 32'(bus.done_o), 32'd0);
      bus.mem_ack_i = 1'b1;
      do_push(16'h0F0F, 16'h5555);
      wait_idle();

      // 6: back-to-back pushes, 4-cycle period
      expect_push(16'hAAAA, 16'hC000);
      expect_push(16'hBBBB, 16'hD000);
      bus.push_i = 1'b1;
      bus.pc_i   = 16'hAAAA;
      bus.sp_i   = 16'hC000;
      tick();
      bus.pc_i = 16'hBBBB;
      bus.sp_i = 16'hD000;
      tick(); tick();
      check("t6_c3_done", 32'(bus.done_o), 32'd1);
      tick();
      check("t6_c4_busy", 32'(bus.busy_o), 32'd0);
      tick();
      bus.push_i = 1'b0;
      check("t6_c5_wr", 32'(bus.mem_wr_o), 32'd1);
      check("t6_c5_addr", 32'(bus.mem_addr_o), 32'hCFFF);
      tick(); tick();
      check("t6_c7_done", 32'(bus.done_o), 32'd1);
      check("t6_c7_sp", 32'(bus.sp_o), 32'hCFFE);
      wait_idle();
      tick(); tick();

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
